// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage states, inter-stage payloads.
// Payload widths feed DATA_W of pipe_stage_reg.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifu2idu_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  gpr_wr_id;
    logic        reg_wr_en;
  } idu2exu_t;

  typedef struct packed {
    logic        reg_wr_en;
    logic [1:0]  reg_wr_src;
    logic [31:0] pc;
    logic [31:0] exu_res;
    logic [31:0] lsu_res;
    logic [4:0]  gpr_wr_id;
  } lsu2wbu_t;

  localparam int IFU2IDU_W = $bits(ifu2idu_t);
  localparam int IDU2EXU_W = $bits(idu2exu_t);
  localparam int LSU2WBU_W = $bits(lsu2wbu_t);

  function automatic logic [1:0] state_cnt(
    input pipe_state_e s
  );
    logic [1:0] c;
    c = 2'd0;
    unique case (s)
      PS_EMPTY: c = 2'd0;
      PS_BUSY:  c = 2'd1;
      PS_FULL:  c = 2'd2;
      default:  c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready stage register.
// Optional skid entry keeps upstream ready registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W  = 64,
  parameter bit              SKID_EN = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_pipe_flush,
  input  logic              i_pre_valid,
  output logic              o_pre_ready,
  input  logic [DATA_W-1:0] i_pre_data,
  output logic              o_nxt_valid,
  input  logic              i_nxt_ready,
  output logic [DATA_W-1:0] o_nxt_data,
  output logic [1:0]        o_stage_cnt
);

  pipe_state_e       state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              acc;
  logic              pop;

  assign acc = i_pre_valid && o_pre_ready;
  assign pop = o_nxt_valid && i_nxt_ready;

  assign o_nxt_valid = (state_q != PS_EMPTY);
  assign o_nxt_data  = main_q;
  assign o_stage_cnt = state_cnt(state_q);

  generate
    if (SKID_EN) begin : g_skid
      assign o_pre_ready = (state_q != PS_FULL);

      // Skid captures the payload that arrives while main is stalled.
      always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
          skid_q <= RST_VAL;
        end else if (!i_pipe_flush &&
                     state_q == PS_BUSY &&
                     acc && !pop) begin
          skid_q <= i_pre_data;
        end
      end
    end else begin : g_noskid
      assign o_pre_ready = (state_q == PS_EMPTY) ||
                           i_nxt_ready;
      assign skid_q      = RST_VAL;
    end
  endgenerate

  // Occupancy FSM and main entry; flush only clears validity.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= PS_EMPTY;
      main_q  <= RST_VAL;
    end else if (i_pipe_flush) begin
      state_q <= PS_EMPTY;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (acc) begin
            state_q <= PS_BUSY;
            main_q  <= i_pre_data;
          end
        end
        PS_BUSY: begin
          unique case (1'b1)
            (acc && pop): main_q <= i_pre_data;
            (acc && !pop): begin
              if (SKID_EN) state_q <= PS_FULL;
            end
            (!acc && pop): state_q <= PS_EMPTY;
            default: ;
          endcase
        end
        PS_FULL: begin
          if (pop) begin
            state_q <= PS_BUSY;
            main_q  <= skid_q;
          end
        end
        default: state_q <= PS_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks for pipe_stage_reg.
// Skid and no-skid instances run side by side.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  logic        s_pv = 1'b0;
  logic        s_pr;
  logic [63:0] s_pd = '0;
  logic        s_nv;
  logic        s_nr = 1'b0;
  logic [63:0] s_nd;
  logic [1:0]  s_cnt;

  logic        n_pv = 1'b0;
  logic        n_pr;
  logic [63:0] n_pd = '0;
  logic        n_nv;
  logic        n_nr = 1'b0;
  logic [63:0] n_nd;
  logic [1:0]  n_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (64),
    .SKID_EN(1'b1),
    .RST_VAL(64'hDEAD)
  ) u_skid (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst),
    .i_pipe_flush(flush),
    .i_pre_valid (s_pv),
    .o_pre_ready (s_pr),
    .i_pre_data  (s_pd),
    .o_nxt_valid (s_nv),
    .i_nxt_ready (s_nr),
    .o_nxt_data  (s_nd),
    .o_stage_cnt (s_cnt)
  );

  pipe_stage_reg #(
    .DATA_W (64),
    .SKID_EN(1'b0),
    .RST_VAL(64'h0)
  ) u_noskid (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst),
    .i_pipe_flush(flush),
    .i_pre_valid (n_pv),
    .o_pre_ready (n_pr),
    .i_pre_data  (n_pd),
    .o_nxt_valid (n_nv),
    .i_nxt_ready (n_nr),
    .o_nxt_data  (n_nd),
    .o_stage_cnt (n_cnt)
  );

  a_stab_s: assert property (
    @(posedge clk) disable iff (rst)
    (s_nv && !s_nr && !flush) |=>
    (s_nv && $stable(s_nd))
  ) else begin
    miscompares++;
    $display("FAIL stab_s: data %h changed", s_nd);
  end

  a_stab_n: assert property (
    @(posedge clk) disable iff (rst)
    (n_nv && !n_nr && !flush) |=>
    (n_nv && $stable(n_nd))
  ) else begin
    miscompares++;
    $display("FAIL stab_n: data %h changed", n_nd);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (s_pr !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_rdy_s: got %b want 1", s_pr);
    end
    vectors++;
    if (n_pr !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_rdy_n: got %b want 1", n_pr);
    end
    vectors++;
    if (s_nd !== 64'hDEAD || s_nv !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_val: got %b/%h want 0/dead",
               s_nv, s_nd);
    end
    s_pv = 1'b1;
    s_pd = 64'h1234;
    s_nr = 1'b0;
    tick();
    s_pv = 1'b0;
    #1;
    vectors++;
    if (s_nv !== 1'b1 || s_nd !== 64'h1234) begin
      miscompares++;
      $display("FAIL rst_load: got %b/%h want 1/1234",
               s_nv, s_nd);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (s_nv !== 1'b0 || s_nd !== 64'hDEAD ||
        s_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_async: got %b/%h/%0d want 0/dead/0",
               s_nv, s_nd, s_cnt);
    end
    vectors++;
    if (n_nv !== 1'b0 || n_nd !== 64'h0) begin
      miscompares++;
      $display("FAIL rst_n: got %b/%h want 0/0", n_nv, n_nd);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (s_pr !== 1'b1 || s_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_rel: got %b/%0d want 1/0",
               s_pr, s_cnt);
    end
  endtask

  task automatic test_stream;
    s_nr = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      s_pv = (k < 8);
      s_pd = 64'(k + 1);
      #1;
      vectors++;
      if (s_pr !== 1'b1) begin
        miscompares++;
        $display("FAIL str_rdy[%0d]: got %b want 1", k, s_pr);
      end
      if (k > 0) begin
        vectors++;
        if (s_nv !== 1'b1 || s_nd !== 64'(k) ||
            s_cnt !== 2'd1) begin
          miscompares++;
          $display("FAIL str_out[%0d]: got %b/%h/%0d want 1/%h/1",
                   k, s_nv, s_nd, s_cnt, 64'(k));
        end
      end
      tick();
    end
    s_pv = 1'b0;
    vectors++;
    if (s_nv !== 1'b0 || s_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL str_end: got %b/%0d want 0/0",
               s_nv, s_cnt);
    end
  endtask

  task automatic test_backpressure;
    s_nr = 1'b0;
    s_pv = 1'b1;
    s_pd = 64'hA;
    tick();
    s_pd = 64'hB;
    #1;
    vectors++;
    if (s_pr !== 1'b1 || s_cnt !== 2'd1) begin
      miscompares++;
      $display("FAIL bp_busy: got %b/%0d want 1/1", s_pr, s_cnt);
    end
    tick();
    s_pd = 64'hC;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (s_cnt !== 2'd2 || s_pr !== 1'b0 ||
          s_nd !== 64'hA || s_nv !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_full[%0d]: got %0d/%b/%h want 2/0/a",
                 k, s_cnt, s_pr, s_nd);
      end
      tick();
    end
    s_nr = 1'b1;
    #1;
    vectors++;
    if (s_nd !== 64'hA) begin
      miscompares++;
      $display("FAIL bp_popA: got %h want a", s_nd);
    end
    tick();
    #1;
    vectors++;
    if (s_nd !== 64'hB || s_pr !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_popB: got %h/%b want b/1", s_nd, s_pr);
    end
    tick();
    s_pv = 1'b0;
    #1;
    vectors++;
    if (s_nd !== 64'hC || s_nv !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_popC: got %b/%h want 1/c", s_nv, s_nd);
    end
    tick();
    vectors++;
    if (s_nv !== 1'b0 || s_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_empty: got %b/%0d want 0/0",
               s_nv, s_cnt);
    end
  endtask

  task automatic test_noskid;
    n_nr = 1'b0;
    n_pv = 1'b1;
    n_pd = 64'hA;
    tick();
    n_pd = 64'hC;
    #1;
    vectors++;
    if (n_pr !== 1'b0 || n_cnt !== 2'd1 ||
        n_nd !== 64'hA) begin
      miscompares++;
      $display("FAIL ns_hold: got %b/%0d/%h want 0/1/a",
               n_pr, n_cnt, n_nd);
    end
    n_nr = 1'b1;
    #1;
    vectors++;
    if (n_pr !== 1'b1) begin
      miscompares++;
      $display("FAIL ns_comb_rdy: got %b want 1", n_pr);
    end
    tick();
    n_pv = 1'b0;
    #1;
    vectors++;
    if (n_cnt !== 2'd1 || n_nd !== 64'hC ||
        n_nv !== 1'b1) begin
      miscompares++;
      $display("FAIL ns_swap: got %0d/%h want 1/c", n_cnt, n_nd);
    end
    tick();
    vectors++;
    if (n_nv !== 1'b0 || n_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL ns_empty: got %b/%0d want 0/0",
               n_nv, n_cnt);
    end
  endtask

  task automatic test_flush;
    s_nr = 1'b0;
    s_pv = 1'b1;
    s_pd = 64'hA;
    tick();
    s_pd = 64'hB;
    tick();
    s_pd = 64'h55;
    flush = 1'b1;
    #1;
    vectors++;
    if (s_cnt !== 2'd2) begin
      miscompares++;
      $display("FAIL fl_pre: got %0d want 2", s_cnt);
    end
    tick();
    flush = 1'b0;
    s_pv = 1'b0;
    #1;
    vectors++;
    if (s_nv !== 1'b0 || s_cnt !== 2'd0 || s_pr !== 1'b1) begin
      miscompares++;
      $display("FAIL fl_full: got %b/%0d/%b want 0/0/1",
               s_nv, s_cnt, s_pr);
    end
    s_pv = 1'b1;
    s_pd = 64'hA;
    tick();
    s_pd = 64'h66;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    s_pv = 1'b0;
    s_nr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (s_nv !== 1'b0 || s_cnt !== 2'd0) begin
        miscompares++;
        $display("FAIL fl_busy[%0d]: got %b/%0d/%h want 0/0",
                 k, s_nv, s_cnt, s_nd);
      end
      tick();
    end
  endtask

  task automatic test_random(input bit sel, input int ncyc);
    int unsigned in_cnt;
    int unsigned out_cnt;
    bit          pv;
    bit          nr;
    logic        pr;
    logic        nv;
    logic [63:0] nd;
    logic [1:0]  cnt;
    in_cnt = 0;
    out_cnt = 0;
    pv = 1'b0;
    for (int c = 0; c < ncyc + 20; c++) begin
      if (!pv && c < ncyc) pv = 1'($urandom_range(0, 1));
      nr = (c >= ncyc) ? 1'b1 : 1'($urandom_range(0, 1));
      if (sel) begin
        n_pv = pv;
        n_pd = 64'(in_cnt + 100);
        n_nr = nr;
      end else begin
        s_pv = pv;
        s_pd = 64'(in_cnt + 100);
        s_nr = nr;
      end
      #1;
      pr  = sel ? n_pr : s_pr;
      nv  = sel ? n_nv : s_nv;
      nd  = sel ? n_nd : s_nd;
      cnt = sel ? n_cnt : s_cnt;
      vectors++;
      if (cnt !== 2'(in_cnt - out_cnt)) begin
        miscompares++;
        $display("FAIL rnd_cnt[%0d/%0d]: got %0d want %0d",
                 sel, c, cnt, in_cnt - out_cnt);
      end
      if (nv && nr) begin
        vectors++;
        if (nd !== 64'(out_cnt + 100)) begin
          miscompares++;
          $display("FAIL rnd_data[%0d/%0d]: got %h want %h",
                   sel, c, nd, 64'(out_cnt + 100));
        end
        out_cnt++;
      end
      if (pv && pr === 1'b1) begin
        in_cnt++;
        pv = 1'b0;
      end
      tick();
    end
    if (sel) n_pv = 1'b0;
    else s_pv = 1'b0;
    vectors++;
    if (out_cnt != in_cnt || in_cnt == 0) begin
      miscompares++;
      $display("FAIL rnd_drain[%0d]: got %0d out want %0d",
               sel, out_cnt, in_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_noskid();
    test_flush();
    test_random(1'b0, 5000);
    test_random(1'b1, 5000);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
